// File: rtl/percept_frame_rx.sv
// -----------------------------------------------------------------------------
// percept_frame_rx
//
// Serial frame receiver for one perceptron node on a shared serial line.
// Each frame is one low start bit, eight data bits sent MSB first, and one high
// stop bit. Each bit lasts one clock. Bytes are paired into (address, payload)
// transactions. A payload whose address byte matched this node goes into a
// one-entry valid/ready holding register.
//
// Errors are reported on sticky flags:
//   frame_err : a stop bit was sampled low. The byte is discarded.
//   overflow  : a matched payload arrived while the holding register was full.
//               The new payload is dropped.
// A half-finished transaction is abandoned if the payload start bit does not
// arrive within TIMEOUT idle cycles after the address byte completes.
//
// Optional feature:
//   PERCEPT_FRAME_RX_BCAST_EN - when defined, address byte 8'hFF matches every
//   node. When undefined, 8'hFF matches only a node whose address is 8'hFF.
// -----------------------------------------------------------------------------
module percept_frame_rx #(
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic [7:0] address,
  input  logic       ready,
  input  logic       clr_err,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       overflow
);

  // Byte-level receiver states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    STOP      = 2'd2,
    WAIT_HIGH = 2'd3
  } rx_state_t;

  // Which byte of an (address, payload) pair is expected next.
  typedef enum logic {
    PH_ADDR    = 1'b0,
    PH_PAYLOAD = 1'b1
  } phase_t;

  // Registered state and its next-state values.
  rx_state_t   state_q,     state_d;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic [7:0]  shift_q,     shift_d;
  phase_t      phase_q,     phase_d;
  logic        match_q,     match_d;
  logic [15:0] gap_q,       gap_d;
  logic [7:0]  data_q,      data_d;
  logic        valid_q,     valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overflow_q,  overflow_d;

  // Single-cycle events passed between the combinational blocks.
  logic        byte_done;     // stop bit high: shift_q holds a complete byte
  logic        stop_err;      // stop bit low: byte discarded
  logic        addr_hit;      // completed byte selects this node
  logic        timeout_hit;   // idle too long between address and payload
  logic        deliver;       // matched payload byte has completed
  logic        overflow_ev;   // matched payload dropped because the holding register is full
  logic [15:0] gap_inc;

  // Address comparison. The broadcast address is optional.
`ifdef PERCEPT_FRAME_RX_BCAST_EN
  assign addr_hit = (shift_q == address) || (shift_q == 8'hFF);
`else
  assign addr_hit = (shift_q == address);
`endif

  // Byte FSM: find the start bit, shift in 8 data bits, then check the stop bit.
  // NOTE: every signal driven here gets a default before the case statement.
  // Otherwise a path that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_err  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!serial_in) begin
          state_d   = SHIFT;
          bit_cnt_d = 3'd7;
        end
      end

      SHIFT: begin
        shift_d   = {shift_q[6:0], serial_in};
        bit_cnt_d = bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd0) begin
          state_d = STOP;
        end
      end

      STOP: begin
        if (serial_in) begin
          byte_done = 1'b1;
          state_d   = IDLE;
        end else begin
          stop_err  = 1'b1;
          state_d   = WAIT_HIGH;
        end
      end

      WAIT_HIGH: begin
        // A line that stays low must not be read as a fresh start bit.
        if (serial_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Transaction tracking: address/payload pairing, match flag and idle-gap timeout.
  always_comb begin
    phase_d     = phase_q;
    match_d     = match_q;
    gap_d       = gap_q;
    deliver     = 1'b0;
    gap_inc     = gap_q + 16'd1;
    timeout_hit = (state_q == IDLE) && (phase_q == PH_PAYLOAD) && (gap_inc >= TIMEOUT);

    if (timeout_hit) begin
      // A start bit sampled on this edge becomes an address byte.
      phase_d = PH_ADDR;
      match_d = 1'b0;
      gap_d   = gap_inc;
    end else if ((state_q == IDLE) && (phase_q == PH_PAYLOAD)) begin
      gap_d   = gap_inc;
    end

    if (byte_done) begin
      if (phase_q == PH_ADDR) begin
        match_d = addr_hit;
        phase_d = PH_PAYLOAD;
        gap_d   = 16'd0;
      end else begin
        phase_d = PH_ADDR;
        deliver = match_q;
      end
    end

    if (stop_err) begin
      phase_d = PH_ADDR;
    end
  end

  // Holding register handshake and sticky error flags.
  always_comb begin
    data_d      = data_q;
    valid_d     = valid_q;
    overflow_ev = 1'b0;

    if (deliver) begin
      // A slot freed by a handshake on this same edge can take the new byte at once.
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overflow_ev = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    // If clr_err and an error event land on the same edge, the event wins.
    frame_err_d = (frame_err_q && !clr_err) || stop_err;
    overflow_d  = (overflow_q  && !clr_err) || overflow_ev;
  end

  // State register for the whole receiver.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values no matter how the process bodies are ordered.
  // NOTE: the shift register and bit counter are reset as well, even though
  // their values do not matter in IDLE. This keeps the post-reset state fully
  // defined, and the datapath is small enough for that to be free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      phase_q     <= PH_ADDR;
      match_q     <= 1'b0;
      gap_q       <= 16'd0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      match_q     <= match_d;
      gap_q       <= gap_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // Every output comes straight from a register. No input reaches an output combinationally.
  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_percept_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_percept_frame_rx
//
// Directed and randomized frame stimulus for percept_frame_rx.
//
// The reference model works at frame level. The frame driver tells it when a
// start bit, a good stop bit or a bad stop bit is sent. The model then applies
// the transaction rules: address/payload pairing, timeout measured from the
// completion of the address byte, holding-register handshake and sticky flags.
//
// Build with PERCEPT_FRAME_RX_BCAST_EN defined to exercise the broadcast address.
// -----------------------------------------------------------------------------
module tb_percept_frame_rx;

  localparam logic [15:0] TIMEOUT_TB = 16'd20;
`ifdef PERCEPT_FRAME_RX_BCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  localparam int EV_NONE     = 0;
  localparam int EV_START    = 1;
  localparam int EV_STOP_OK  = 2;
  localparam int EV_STOP_BAD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [7:0] address;
  logic       ready;
  logic       clr_err;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       overflow;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state.
  bit       m_valid;
  bit [7:0] m_data;
  bit       m_ovf;
  bit       m_ferr;
  bit       m_payload_phase;
  bit       m_match;
  int       m_addr_cyc;
  int       cyc;

  percept_frame_rx #(
    .TIMEOUT(TIMEOUT_TB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .address   (address),
    .ready     (ready),
    .clr_err   (clr_err),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid         = 1'b0;
    m_data          = 8'h00;
    m_ovf           = 1'b0;
    m_ferr          = 1'b0;
    m_payload_phase = 1'b0;
    m_match         = 1'b0;
    m_addr_cyc      = 0;
  endtask

  // Apply one clock edge's worth of transaction rules.
  task automatic model_edge(input int ev, input logic [7:0] b);
    bit delivered = 1'b0;
    bit ovf_ev    = 1'b0;
    bit err_ev    = 1'b0;
    cyc++;
    case (ev)
      EV_START: begin
        if (m_payload_phase && ((cyc - m_addr_cyc) >= int'(TIMEOUT_TB))) begin
          m_payload_phase = 1'b0;
          m_match         = 1'b0;
        end
      end
      EV_STOP_OK: begin
        if (!m_payload_phase) begin
          m_match         = (b == address) || (BCAST && (b == 8'hFF));
          m_payload_phase = 1'b1;
          m_addr_cyc      = cyc;
        end else begin
          m_payload_phase = 1'b0;
          if (m_match) begin
            if (!m_valid || ready) begin
              m_data    = b;
              m_valid   = 1'b1;
              delivered = 1'b1;
            end else begin
              ovf_ev = 1'b1;
            end
          end
        end
      end
      EV_STOP_BAD: begin
        err_ev          = 1'b1;
        m_payload_phase = 1'b0;
      end
      default: ;
    endcase
    if (!delivered && m_valid && ready) m_valid = 1'b0;
    m_ferr = (m_ferr && !clr_err) || err_ev;
    m_ovf  = (m_ovf && !clr_err) || ovf_ev;
  endtask

  // Drive one bit for one clock. Outputs are settled 1 time unit after the edge.
  task automatic cycle(input logic sin, input int ev, input logic [7:0] b);
    serial_in = sin;
    @(posedge clk);
    model_edge(ev, b);
    #1;
  endtask

  // Send one full frame, then gap idle-high cycles.
  // A bad frame holds the line low for low_hold cycles, starting at the stop bit.
  task automatic send_frame(input logic [7:0] b, input bit good, input int gap,
                            input int low_hold, input bit rdy_at_stop, input bit clr_at_stop);
    int g;
    cycle(1'b0, EV_START, b);
    for (int i = 7; i >= 0; i--) cycle(b[i], EV_NONE, b);
    if (rdy_at_stop) ready = 1'b1;
    if (clr_at_stop) clr_err = 1'b1;
    if (good) begin
      cycle(1'b1, EV_STOP_OK, b);
    end else begin
      cycle(1'b0, EV_STOP_BAD, b);
    end
    clr_err = 1'b0;
    g = gap;
    if (!good) begin
      for (int i = 1; i < low_hold; i++) cycle(1'b0, EV_NONE, b);
      if (g < 1) g = 1;
    end
    for (int i = 0; i < g; i++) cycle(1'b1, EV_NONE, b);
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    serial_in = 1'b1;
    address   = 8'h02;
    ready     = 1'b0;
    clr_err   = 1'b0;
    cyc       = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if ({valid, data_out, overflow, frame_err} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_values: got v=%b d=%h ovf=%b ferr=%b, want all zero",
               valid, data_out, overflow, frame_err);
    end
    rst = 1'b0;
    cycle(1'b1, EV_NONE, 8'h00);
    cycle(1'b1, EV_NONE, 8'h00);
    compared++;
    if ({valid, data_out, overflow, frame_err} !== 11'd0) begin
      mismatched++;
      $display("FAIL idle_after_reset: got v=%b d=%h ovf=%b ferr=%b, want all zero",
               valid, data_out, overflow, frame_err);
    end
  endtask

  task automatic test_basic_deliver();
    ready = 1'b1;
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'hA5) begin
      mismatched++;
      $display("FAIL basic_deliver: got v=%b d=%h, want v=1 d=a5", valid, data_out);
    end
    cycle(1'b1, EV_NONE, 8'h00);
    compared++;
    if (valid !== 1'b0 || data_out !== 8'hA5) begin
      mismatched++;
      $display("FAIL basic_pulse_end: got v=%b d=%h, want v=0 d=a5", valid, data_out);
    end
  endtask

  task automatic test_no_match();
    send_frame(8'h01, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 2, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b0 || data_out !== 8'hA5) begin
      mismatched++;
      $display("FAIL other_node: got v=%b d=%h, want v=0 d=a5", valid, data_out);
    end
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'h11) begin
      mismatched++;
      $display("FAIL match_after_other: got v=%b d=%h, want v=1 d=11", valid, data_out);
    end
    cycle(1'b1, EV_NONE, 8'h00);
  endtask

  task automatic test_overflow();
    ready = 1'b0;
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h10, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'h10 || overflow !== 1'b0) begin
      mismatched++;
      $display("FAIL ovf_first: got v=%b d=%h ovf=%b, want v=1 d=10 ovf=0", valid, data_out, overflow);
    end
    send_frame(8'h02, 1'b1, 1, 0, 1'b0, 1'b0);
    send_frame(8'h20, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'h10 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_drop: got v=%b d=%h ovf=%b, want v=1 d=10 ovf=1", valid, data_out, overflow);
    end
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h30, 1'b1, 0, 0, 1'b1, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'h30 || overflow !== 1'b1) begin
      mismatched++;
      $display("FAIL ovf_same_edge_load: got v=%b d=%h ovf=%b, want v=1 d=30 ovf=1", valid, data_out, overflow);
    end
    cycle(1'b1, EV_NONE, 8'h00);
    compared++;
    if (valid !== 1'b0 || data_out !== 8'h30) begin
      mismatched++;
      $display("FAIL ovf_consumed: got v=%b d=%h, want v=0 d=30", valid, data_out);
    end
  endtask

  task automatic test_frame_err();
    clr_err = 1'b1;
    cycle(1'b1, EV_NONE, 8'h00);
    clr_err = 1'b0;
    compared++;
    if (overflow !== 1'b0 || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL clr_ovf: got ovf=%b ferr=%b, want 0 0", overflow, frame_err);
    end
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1, 5, 1'b0, 1'b1);
    compared++;
    if (frame_err !== 1'b1 || valid !== 1'b0 || data_out !== 8'h30) begin
      mismatched++;
      $display("FAIL frame_err_set: got ferr=%b v=%b d=%h, want ferr=1 v=0 d=30", frame_err, valid, data_out);
    end
    clr_err = 1'b1;
    cycle(1'b1, EV_NONE, 8'h00);
    clr_err = 1'b0;
    compared++;
    if (frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL frame_err_clear: got ferr=%b, want 0", frame_err);
    end
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'h3C || frame_err !== 1'b0) begin
      mismatched++;
      $display("FAIL after_frame_err: got v=%b d=%h ferr=%b, want v=1 d=3c ferr=0", valid, data_out, frame_err);
    end
    cycle(1'b1, EV_NONE, 8'h00);
  endtask

  task automatic test_timeout();
    send_frame(8'h02, 1'b1, 25, 0, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'h77) begin
      mismatched++;
      $display("FAIL timeout_discard: got v=%b d=%h, want v=1 d=77", valid, data_out);
    end
    cycle(1'b1, EV_NONE, 8'h00);
    send_frame(8'h02, 1'b1, 3, 0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'h44) begin
      mismatched++;
      $display("FAIL short_gap: got v=%b d=%h, want v=1 d=44", valid, data_out);
    end
    cycle(1'b1, EV_NONE, 8'h00);
  endtask

  task automatic test_bcast();
    logic [7:0] want_d;
    want_d  = BCAST ? 8'h5A : 8'h44;
    address = 8'h03;
    send_frame(8'hFF, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== BCAST || data_out !== want_d) begin
      mismatched++;
      $display("FAIL bcast_addr: got v=%b d=%h, want v=%b d=%h", valid, data_out, BCAST, want_d);
    end
    cycle(1'b1, EV_NONE, 8'h00);
    address = 8'h02;
  endtask

  task automatic test_back_to_back();
    logic [7:0] p;
    ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      p = 8'($urandom);
      send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
      send_frame(p, 1'b1, 0, 0, 1'b0, 1'b0);
      compared++;
      if (valid !== 1'b1 || data_out !== p) begin
        mismatched++;
        $display("FAIL back_to_back[%0d]: got v=%b d=%h, want v=1 d=%h", i, valid, data_out, p);
      end
    end
    cycle(1'b1, EV_NONE, 8'h00);
  endtask

  task automatic test_reset_mid();
    logic [7:0] p;
    p     = 8'hC3;
    ready = 1'b0;
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'h66, 1'b1, 1, 0, 1'b0, 1'b0);
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    cycle(1'b0, EV_START, p);
    for (int i = 7; i >= 5; i--) cycle(p[i], EV_NONE, p);
    serial_in = p[4];
    #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({valid, data_out, overflow, frame_err} !== 11'd0) begin
      mismatched++;
      $display("FAIL reset_mid_frame: got v=%b d=%h ovf=%b ferr=%b, want all zero",
               valid, data_out, overflow, frame_err);
    end
    model_reset();
    serial_in = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = 1'b1;
    cycle(1'b1, EV_NONE, 8'h00);
    send_frame(8'h02, 1'b1, 0, 0, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 0, 0, 1'b0, 1'b0);
    compared++;
    if (valid !== 1'b1 || data_out !== 8'hFF) begin
      mismatched++;
      $display("FAIL after_reset_mid: got v=%b d=%h, want v=1 d=ff", valid, data_out);
    end
    cycle(1'b1, EV_NONE, 8'h00);
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] p;
    int         r;
    int         gap_a;
    bit         good_a;
    bit         good_p;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(7) == 0) begin
        clr_err = 1'b1;
        cycle(1'b1, EV_NONE, 8'h00);
        clr_err = 1'b0;
      end
      ready  = ($urandom_range(3) != 0);
      r      = int'($urandom_range(9));
      a      = (r < 6) ? 8'h02 : (r == 6) ? 8'hFF : 8'($urandom);
      p      = 8'($urandom);
      good_a = ($urandom_range(15) != 0);
      good_p = ($urandom_range(11) != 0);
      gap_a  = ($urandom_range(7) == 0) ? 25 : int'($urandom_range(3));
      send_frame(a, good_a, gap_a, int'($urandom_range(4, 1)), 1'b0, 1'b0);
      send_frame(p, good_p, int'($urandom_range(3)), int'($urandom_range(4, 1)), 1'b0, 1'b0);
      compared++;
      if ({valid, data_out, overflow, frame_err} !== {m_valid, m_data, m_ovf, m_ferr}) begin
        mismatched++;
        $display("FAIL random[%0d]: got v=%b d=%h ovf=%b ferr=%b, want v=%b d=%h ovf=%b ferr=%b",
                 i, valid, data_out, overflow, frame_err, m_valid, m_data, m_ovf, m_ferr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_deliver();
    test_no_match();
    test_overflow();
    test_frame_err();
    test_timeout();
    test_bcast();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
